// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its decode-side consumer.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        misalign;
    } if_id_t;

    typedef enum logic [2:0] {
        FC_REDIRECT,
        FC_STALL,
        FC_WAIT,
        FC_MISALIGN,
        FC_FETCH
    } fetch_case_e;

    // Resolve the single action for this cycle, highest priority first.
    function automatic fetch_case_e resolveCase(
        input logic redirect,
        input logic stall,
        input logic imemReady,
        input logic pcBit1
    );
        if (redirect)        return FC_REDIRECT;
        else if (stall)      return FC_STALL;
        else if (!imemReady) return FC_WAIT;
        else if (pcBit1)     return FC_MISALIGN;
        else                 return FC_FETCH;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with the next-PC priority mux.
module fetch_stage_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_imem_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output fetch_case_e o_fetch_case
);

    logic [31:0] r_pc;
    logic [31:0] w_pcPlus4;
    fetch_case_e w_fetchCase;

    assign w_pcPlus4   = r_pc + 32'd4;
    assign w_fetchCase = resolveCase(i_redirect, i_stall, i_imem_ready, r_pc[1]);

    // Advance, redirect or hold the PC; a misaligned PC holds until redirected.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else begin
            case (w_fetchCase)
                FC_REDIRECT: r_pc <= i_redirect_pc & ~32'd1;
                FC_FETCH:    r_pc <= w_pcPlus4;
                default:     r_pc <= r_pc;
            endcase
        end
    end

    assign o_pc         = r_pc;
    assign o_pc_plus4   = w_pcPlus4;
    assign o_fetch_case = w_fetchCase;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the fetch address and holds the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ready,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc4,
    output logic        o_if_id_valid,
    output logic        o_if_id_misalign
);

    logic [31:0] w_pc;
    logic [31:0] w_pcPlus4;
    fetch_case_e w_fetchCase;
    if_id_t      r_ifId;
    if_id_t      w_bubble;

    fetch_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pcReg (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_imem_ready  (i_imem_ready),
        .o_pc          (w_pc),
        .o_pc_plus4    (w_pcPlus4),
        .o_fetch_case  (w_fetchCase)
    );

    assign w_bubble = '{instr: NOP, pc: 32'd0, pc4: 32'd0, valid: 1'b0, misalign: 1'b0};

    // Load, bubble or hold the IF/ID register according to the cycle's action.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ifId <= w_bubble;
        end else begin
            case (w_fetchCase)
                FC_STALL:    r_ifId <= r_ifId;
                FC_MISALIGN: r_ifId <= '{instr: NOP, pc: w_pc, pc4: w_pcPlus4,
                                         valid: 1'b0, misalign: 1'b1};
                FC_FETCH:    r_ifId <= '{instr: i_imem_rdata, pc: w_pc, pc4: w_pcPlus4,
                                         valid: 1'b1, misalign: 1'b0};
                default:     r_ifId <= w_bubble;
            endcase
        end
    end

    assign o_imem_addr      = w_pc;
    assign o_if_id_instr    = r_ifId.instr;
    assign o_if_id_pc       = r_ifId.pc;
    assign o_if_id_pc4      = r_ifId.pc4;
    assign o_if_id_valid    = r_ifId.valid;
    assign o_if_id_misalign = r_ifId.misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a scoreboard of expected IF/ID states.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemReady;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPc;
    logic [31:0] ifIdPc4;
    logic        ifIdValid;
    logic        ifIdMisalign;

    int checkCount;
    int errCount;

    logic [31:0] mPc;
    if_id_t      mIfId;
    if_id_t      expQ[$];
    logic [31:0] expPcQ[$];

    fetch_stage dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall          (stall),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirectPc),
        .o_imem_addr      (imemAddr),
        .i_imem_rdata     (imemRdata),
        .i_imem_ready     (imemReady),
        .o_if_id_instr    (ifIdInstr),
        .o_if_id_pc       (ifIdPc),
        .o_if_id_pc4      (ifIdPc4),
        .o_if_id_valid    (ifIdValid),
        .o_if_id_misalign (ifIdMisalign)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents used by both the memory model and the scoreboard.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            default:       return addr ^ 32'h1357_9BDF;
        endcase
    endfunction

    assign imemRdata = memWord(imemAddr);

    function automatic if_id_t bubbleVal();
        if_id_t b;
        b.instr    = 32'h0000_0013;
        b.pc       = 32'd0;
        b.pc4      = 32'd0;
        b.valid    = 1'b0;
        b.misalign = 1'b0;
        return b;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checkCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Pop the expected state for this cycle and compare every output.
    task automatic checkOutput(input string tag);
        if_id_t      e;
        logic [31:0] ePc;
        if (expQ.size() == 0) begin
            checkCount++;
            errCount++;
            $display("[TB] FAIL %s: scoreboard empty", tag);
        end else begin
            e   = expQ.pop_front();
            ePc = expPcQ.pop_front();
            check32({tag, ".imem_addr"}, imemAddr, ePc);
            check32({tag, ".instr"}, ifIdInstr, e.instr);
            check32({tag, ".pc"}, ifIdPc, e.pc);
            check32({tag, ".pc4"}, ifIdPc4, e.pc4);
            check1({tag, ".valid"}, ifIdValid, e.valid);
            check1({tag, ".misalign"}, ifIdMisalign, e.misalign);
        end
    endtask

    task automatic checkReset(input string tag);
        check32({tag, ".imem_addr"}, imemAddr, 32'h0000_0000);
        check32({tag, ".instr"}, ifIdInstr, 32'h0000_0013);
        check32({tag, ".pc"}, ifIdPc, 32'd0);
        check32({tag, ".pc4"}, ifIdPc4, 32'd0);
        check1({tag, ".valid"}, ifIdValid, 1'b0);
        check1({tag, ".misalign"}, ifIdMisalign, 1'b0);
    endtask

    // Drive one cycle of inputs (called at a falling edge), update the reference
    // model, push its expectation, then compare just after the rising edge.
    task automatic applyStimulus(input string tag, input logic st, input logic rd,
                                 input logic [31:0] rpc, input logic rdy);
        stall      = st;
        redirect   = rd;
        redirectPc = rpc;
        imemReady  = rdy;
        if (rd) begin
            mIfId = bubbleVal();
            mPc   = {rpc[31:1], 1'b0};
        end else if (st) begin
            mIfId = mIfId;
        end else if (!rdy) begin
            mIfId = bubbleVal();
        end else if (mPc[1]) begin
            mIfId.instr    = 32'h0000_0013;
            mIfId.pc       = mPc;
            mIfId.pc4      = mPc + 32'd4;
            mIfId.valid    = 1'b0;
            mIfId.misalign = 1'b1;
        end else begin
            mIfId.instr    = memWord(mPc);
            mIfId.pc       = mPc;
            mIfId.pc4      = mPc + 32'd4;
            mIfId.valid    = 1'b1;
            mIfId.misalign = 1'b0;
            mPc            = mPc + 32'd4;
        end
        expQ.push_back(mIfId);
        expPcQ.push_back(mPc);
        @(posedge clk);
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    initial begin
        checkCount = 0;
        errCount   = 0;
        rst        = 1'b1;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'd0;
        imemReady  = 1'b1;
        mPc        = 32'h0000_0000;
        mIfId      = bubbleVal();

        @(negedge clk);
        checkReset("reset");
        rst = 1'b0;

        applyStimulus("fetch0", 1'b0, 1'b0, 32'd0, 1'b1);
        check32("firstInstr", ifIdInstr, 32'h0050_0093);
        applyStimulus("fetch4", 1'b0, 1'b0, 32'd0, 1'b1);
        check32("secondInstr", ifIdInstr, 32'h00A0_0113);

        for (int i = 0; i < 3; i++) applyStimulus("stall", 1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus("fetch8", 1'b0, 1'b0, 32'd0, 1'b1);
        check32("afterStallPc", ifIdPc, 32'h0000_0008);

        for (int i = 0; i < 2; i++) applyStimulus("wait", 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus("fetch12", 1'b0, 1'b0, 32'd0, 1'b1);

        applyStimulus("redirStall", 1'b1, 1'b1, 32'h0000_0100, 1'b1);
        applyStimulus("fetch100", 1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus("stallNoReady", 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus("fetch104", 1'b0, 1'b0, 32'd0, 1'b1);

        applyStimulus("redirOdd", 1'b0, 1'b1, 32'h0000_0203, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus("misalign", 1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus("misalignStall", 1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus("redir300", 1'b0, 1'b1, 32'h0000_0300, 1'b1);
        applyStimulus("fetch300", 1'b0, 1'b0, 32'd0, 1'b1);

        applyStimulus("redirTop", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        applyStimulus("fetchTop", 1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus("fetchWrap", 1'b0, 1'b0, 32'd0, 1'b1);

        applyStimulus("redir3c", 1'b0, 1'b1, 32'h0000_003C, 1'b1);
        applyStimulus("fetch3c", 1'b0, 1'b0, 32'd0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkReset("asyncReset");
        @(negedge clk);
        rst   = 1'b0;
        mPc   = 32'h0000_0000;
        mIfId = bubbleVal();
        applyStimulus("restart0", 1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus("restart4", 1'b0, 1'b0, 32'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
